// File: rtl/ex_mem.sv
// EX/MEM pipeline register with stall/flush handling and the multi-cycle accumulator feedback path.
// Optional performance counters are enabled with the EX_MEM_PERF_EN macro.
module ex_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_ex_i,
    input  logic        stall_mem_i,
    input  logic        flush_i,
    input  logic [4:0]  ex_wd_i,
    input  logic        ex_wreg_i,
    input  logic [31:0] ex_wdata_i,
    input  logic [31:0] ex_hi_i,
    input  logic [31:0] ex_lo_i,
    input  logic        ex_whilo_i,
    input  logic [63:0] ex_hilo_temp_i,
    input  logic [1:0]  ex_cnt_i,
    output logic [4:0]  mem_wd_o,
    output logic        mem_wreg_o,
    output logic [31:0] mem_wdata_o,
    output logic [31:0] mem_hi_o,
    output logic [31:0] mem_lo_o,
    output logic        mem_whilo_o,
    output logic [63:0] hilo_temp_o,
    output logic [1:0]  cnt_o,
    output logic [31:0] perf_bubble_o,
    output logic [31:0] perf_hilo_o
);

    typedef enum logic [2:0] {
        UPD_FLUSH,    // bubble, drop accumulator
        UPD_BUBBLE,   // bubble, keep accumulating
        UPD_STALL,    // hold mem_*, keep accumulating
        UPD_CAPTURE,  // normal advance
        UPD_FREEZE    // controller never issues this; hold everything
    } upd_e;

    upd_e upd;

    always_comb begin
        upd = UPD_FREEZE;
        if (flush_i) begin
            upd = UPD_FLUSH;
        end else if (stall_ex_i && !stall_mem_i) begin
            upd = UPD_BUBBLE;
        end else if (stall_ex_i && stall_mem_i) begin
            upd = UPD_STALL;
        end else if (!stall_mem_i) begin
            upd = UPD_CAPTURE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wd_o    <= '0;
            mem_wreg_o  <= 1'b0;
            mem_wdata_o <= '0;
            mem_hi_o    <= '0;
            mem_lo_o    <= '0;
            mem_whilo_o <= 1'b0;
        end else begin
            case (upd)
                UPD_FLUSH, UPD_BUBBLE: begin
                    mem_wd_o    <= '0;
                    mem_wreg_o  <= 1'b0;
                    mem_wdata_o <= '0;
                    mem_hi_o    <= '0;
                    mem_lo_o    <= '0;
                    mem_whilo_o <= 1'b0;
                end
                UPD_CAPTURE: begin
                    mem_wd_o    <= ex_wd_i;
                    // Writes to $0 are dropped here so later stages never see them.
                    mem_wreg_o  <= ex_wreg_i && (ex_wd_i != 5'd0);
                    mem_wdata_o <= ex_wdata_i;
                    mem_hi_o    <= ex_hi_i;
                    mem_lo_o    <= ex_lo_i;
                    mem_whilo_o <= ex_whilo_i;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hilo_temp_o <= '0;
            cnt_o       <= '0;
        end else begin
            case (upd)
                UPD_BUBBLE, UPD_STALL: begin
                    hilo_temp_o <= ex_hilo_temp_i;
                    cnt_o       <= ex_cnt_i;
                end
                UPD_FLUSH, UPD_CAPTURE: begin
                    hilo_temp_o <= '0;
                    cnt_o       <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef EX_MEM_PERF_EN
    logic [31:0] perf_bubble_q;
    logic [31:0] perf_hilo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_bubble_q <= '0;
            perf_hilo_q   <= '0;
        end else begin
            if (upd == UPD_FLUSH || upd == UPD_BUBBLE) begin
                perf_bubble_q <= perf_bubble_q + 32'd1;
            end
            if (upd == UPD_CAPTURE && ex_whilo_i) begin
                perf_hilo_q <= perf_hilo_q + 32'd1;
            end
        end
    end

    assign perf_bubble_o = perf_bubble_q;
    assign perf_hilo_o   = perf_hilo_q;
`else
    assign perf_bubble_o = '0;
    assign perf_hilo_o   = '0;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Bench for ex_mem: directed vector table, hand-written corner sequences and random stimulus
// checked against a rule-level model of the pipeline register.
module tb_ex_mem;

`ifdef EX_MEM_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk, rst;
    logic        stall_ex_i, stall_mem_i, flush_i;
    logic [4:0]  ex_wd_i;
    logic        ex_wreg_i;
    logic [31:0] ex_wdata_i, ex_hi_i, ex_lo_i;
    logic        ex_whilo_i;
    logic [63:0] ex_hilo_temp_i;
    logic [1:0]  ex_cnt_i;
    logic [4:0]  mem_wd_o;
    logic        mem_wreg_o;
    logic [31:0] mem_wdata_o, mem_hi_o, mem_lo_o;
    logic        mem_whilo_o;
    logic [63:0] hilo_temp_o;
    logic [1:0]  cnt_o;
    logic [31:0] perf_bubble_o, perf_hilo_o;

    ex_mem dut (
        .clk(clk), .rst(rst),
        .stall_ex_i(stall_ex_i), .stall_mem_i(stall_mem_i), .flush_i(flush_i),
        .ex_wd_i(ex_wd_i), .ex_wreg_i(ex_wreg_i), .ex_wdata_i(ex_wdata_i),
        .ex_hi_i(ex_hi_i), .ex_lo_i(ex_lo_i), .ex_whilo_i(ex_whilo_i),
        .ex_hilo_temp_i(ex_hilo_temp_i), .ex_cnt_i(ex_cnt_i),
        .mem_wd_o(mem_wd_o), .mem_wreg_o(mem_wreg_o), .mem_wdata_o(mem_wdata_o),
        .mem_hi_o(mem_hi_o), .mem_lo_o(mem_lo_o), .mem_whilo_o(mem_whilo_o),
        .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o),
        .perf_bubble_o(perf_bubble_o), .perf_hilo_o(perf_hilo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference state: what the memory stage and execute feedback should hold.
    logic [4:0]  m_wd;
    logic        m_wreg;
    logic [31:0] m_wdata, m_hi, m_lo;
    logic        m_whilo;
    logic [63:0] m_ht;
    logic [1:0]  m_cnt;
    logic [31:0] m_pb, m_ph;

    typedef struct {
        logic        flush, sex, smem;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata, hi, lo;
        logic        whilo;
        logic [63:0] ht;
        logic [1:0]  cnt;
        logic [4:0]  e_wd;
        logic        e_wreg;
        logic [31:0] e_wdata, e_hi, e_lo;
        logic        e_whilo;
        logic [63:0] e_ht;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wd = '0; m_wreg = 1'b0; m_wdata = '0; m_hi = '0; m_lo = '0; m_whilo = 1'b0;
        m_ht = '0; m_cnt = '0; m_pb = '0; m_ph = '0;
    endtask

    task automatic model_bubble();
        m_wd = '0; m_wreg = 1'b0; m_wdata = '0; m_hi = '0; m_lo = '0; m_whilo = 1'b0;
    endtask

    // Rule-priority view of one clock edge, from the current inputs.
    task automatic model_edge();
        if (flush_i) begin
            model_bubble();
            m_ht = '0; m_cnt = '0; m_pb = m_pb + 1;
        end else if (stall_ex_i && !stall_mem_i) begin
            model_bubble();
            m_ht = ex_hilo_temp_i; m_cnt = ex_cnt_i; m_pb = m_pb + 1;
        end else if (stall_ex_i) begin
            m_ht = ex_hilo_temp_i; m_cnt = ex_cnt_i;
        end else if (!stall_mem_i) begin
            m_wd = ex_wd_i; m_wreg = ex_wreg_i && (ex_wd_i != 0); m_wdata = ex_wdata_i;
            m_hi = ex_hi_i; m_lo = ex_lo_i; m_whilo = ex_whilo_i;
            m_ht = '0; m_cnt = '0;
            if (ex_whilo_i) m_ph = m_ph + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".wd"},    {59'd0, mem_wd_o},    {59'd0, m_wd});
        chk({tag, ".wreg"},  {63'd0, mem_wreg_o},  {63'd0, m_wreg});
        chk({tag, ".wdata"}, {32'd0, mem_wdata_o}, {32'd0, m_wdata});
        chk({tag, ".hi"},    {32'd0, mem_hi_o},    {32'd0, m_hi});
        chk({tag, ".lo"},    {32'd0, mem_lo_o},    {32'd0, m_lo});
        chk({tag, ".whilo"}, {63'd0, mem_whilo_o}, {63'd0, m_whilo});
        chk({tag, ".ht"},    hilo_temp_o,          m_ht);
        chk({tag, ".cnt"},   {62'd0, cnt_o},       {62'd0, m_cnt});
        chk({tag, ".pbub"},  {32'd0, perf_bubble_o}, PERF ? {32'd0, m_pb} : 64'd0);
        chk({tag, ".philo"}, {32'd0, perf_hilo_o},   PERF ? {32'd0, m_ph} : 64'd0);
    endtask

    task automatic drive(input logic fl, input logic sx, input logic sm, input logic [4:0] wd,
                         input logic wr, input logic [31:0] wdata, input logic [31:0] hi,
                         input logic [31:0] lo, input logic wh, input logic [63:0] ht,
                         input logic [1:0] cnt);
        flush_i = fl; stall_ex_i = sx; stall_mem_i = sm; ex_wd_i = wd; ex_wreg_i = wr;
        ex_wdata_i = wdata; ex_hi_i = hi; ex_lo_i = lo; ex_whilo_i = wh;
        ex_hilo_temp_i = ht; ex_cnt_i = cnt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // flush sex smem wd wreg wdata hi lo whilo ht cnt | e_wd e_wreg e_wdata e_hi e_lo e_whilo e_ht e_cnt
        tbl[0] = '{1'b0,1'b0,1'b0, 5'd3, 1'b1, 32'hDEADBEEF, 32'h1, 32'h2, 1'b1, 64'hAAAA, 2'd3,
                   5'd3, 1'b1, 32'hDEADBEEF, 32'h1, 32'h2, 1'b1, 64'h0, 2'd0};
        tbl[1] = '{1'b0,1'b0,1'b0, 5'd0, 1'b1, 32'h55, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0,
                   5'd0, 1'b0, 32'h55, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0};
        tbl[2] = '{1'b0,1'b1,1'b0, 5'd7, 1'b1, 32'h9, 32'h5, 32'h6, 1'b1, 64'h00000001_FFFFFFFE, 2'd1,
                   5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h00000001_FFFFFFFE, 2'd1};
        tbl[3] = '{1'b0,1'b0,1'b0, 5'd4, 1'b1, 32'h11, 32'h3, 32'h4, 1'b0, 64'h1234, 2'd2,
                   5'd4, 1'b1, 32'h11, 32'h3, 32'h4, 1'b0, 64'h0, 2'd0};
        tbl[4] = '{1'b0,1'b1,1'b1, 5'd9, 1'b1, 32'h77, 32'h8, 32'h8, 1'b1, 64'h123, 2'd3,
                   5'd4, 1'b1, 32'h11, 32'h3, 32'h4, 1'b0, 64'h123, 2'd3};
        tbl[5] = '{1'b1,1'b1,1'b1, 5'd9, 1'b1, 32'h77, 32'h8, 32'h8, 1'b1, 64'h456, 2'd2,
                   5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0};
        tbl[6] = '{1'b0,1'b0,1'b0, 5'd31, 1'b1, 32'hFFFFFFFF, 32'hA, 32'hB, 1'b1, 64'h1, 2'd1,
                   5'd31, 1'b1, 32'hFFFFFFFF, 32'hA, 32'hB, 1'b1, 64'h0, 2'd0};
        tbl[7] = '{1'b0,1'b0,1'b1, 5'd2, 1'b0, 32'h3, 32'hC, 32'hD, 1'b1, 64'h999, 2'd1,
                   5'd31, 1'b1, 32'hFFFFFFFF, 32'hA, 32'hB, 1'b1, 64'h0, 2'd0};

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 64'd0, 2'd0);
        model_reset();
        #12;
        check_model("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(tbl[i].flush, tbl[i].sex, tbl[i].smem, tbl[i].wd, tbl[i].wreg, tbl[i].wdata,
                  tbl[i].hi, tbl[i].lo, tbl[i].whilo, tbl[i].ht, tbl[i].cnt);
            tick();
            chk($sformatf("vec%0d.wd", i),    {59'd0, mem_wd_o},    {59'd0, tbl[i].e_wd});
            chk($sformatf("vec%0d.wreg", i),  {63'd0, mem_wreg_o},  {63'd0, tbl[i].e_wreg});
            chk($sformatf("vec%0d.wdata", i), {32'd0, mem_wdata_o}, {32'd0, tbl[i].e_wdata});
            chk($sformatf("vec%0d.hi", i),    {32'd0, mem_hi_o},    {32'd0, tbl[i].e_hi});
            chk($sformatf("vec%0d.lo", i),    {32'd0, mem_lo_o},    {32'd0, tbl[i].e_lo});
            chk($sformatf("vec%0d.whilo", i), {63'd0, mem_whilo_o}, {63'd0, tbl[i].e_whilo});
            chk($sformatf("vec%0d.ht", i),    hilo_temp_o,          tbl[i].e_ht);
            chk($sformatf("vec%0d.cnt", i),   {62'd0, cnt_o},       {62'd0, tbl[i].e_cnt});
        end
        // Table holds two bubble edges (vec2, vec5) and two HI/LO captures (vec0, vec6).
        chk("tbl.pbub",  {32'd0, perf_bubble_o}, PERF ? 64'd2 : 64'd0);
        chk("tbl.philo", {32'd0, perf_hilo_o},   PERF ? 64'd2 : 64'd0);

        // Reset asserted between edges must clear everything without waiting for clk.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 32'h12345678, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0);
        tick();
        chk("rstmid.pre", {32'd0, mem_wdata_o}, 64'h12345678);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_model("rstmid");
        @(negedge clk);
        rst = 1'b0;

`ifdef EX_MEM_PERF_EN
        @(negedge clk);
        force dut.perf_hilo_q = 32'hFFFFFFFF;
        #1;
        release dut.perf_hilo_q;
        drive(1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 32'h1, 32'h2, 32'h3, 1'b1, 64'h0, 2'd0);
        tick();
        m_ph = 32'd0;
        chk("wrap.philo", {32'd0, perf_hilo_o}, 64'd0);
`endif

        for (int i = 0; i < 2000; i++) begin
            logic fl, sx, sm;
            @(negedge clk);
            fl = ($urandom % 10) == 0;
            sx = ($urandom % 3) == 0;
            sm = sx ? ($urandom % 2 == 1) : ($urandom % 12 == 0);
            drive(fl, sx, sm, 5'($urandom % 4 == 0 ? 0 : $urandom), 1'($urandom), $urandom,
                  $urandom, $urandom, 1'($urandom), {$urandom, $urandom}, 2'($urandom));
            tick();
            check_model($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ex_mem.md
# ex_mem

Pipeline register between the execute and memory-access stages of the five-stage MIPS core. It captures the execute-stage results on each rising clock edge:

- destination register write;
- HI/LO write request and data.

It applies the controller's stall and flush rules. It also holds the 64-bit scratch accumulator and cycle counter that multi-cycle execute operations (MADD/MSUB-style, two passes) feed back into the execute stage while that stage is stalled.

## Interface
Parameters:
- none; widths follow the global bus defines (RegBus = 32, RegAddrBus = 5, DoubleRegBus = 64).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high (ports `clk`, `rst`).
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_ex_i  in  1  execute stage stalled this cycle.
- stall_mem_i  in  1  memory stage stalled this cycle.
- flush_i  in  1  discard the execute-stage instruction; load a bubble.
- ex_wd_i  in  5  destination register address.
- ex_wreg_i  in  1  destination write enable.
- ex_wdata_i  in  32  destination write data.
- ex_hi_i  in  32  HI write data.
- ex_lo_i  in  32  LO write data.
- ex_whilo_i  in  1  HI/LO write enable.
- ex_hilo_temp_i  in  64  partial accumulate result from execute.
- ex_cnt_i  in  2  execute multi-cycle pass counter.
- mem_wd_o  out  5  registered destination address.
- mem_wreg_o  out  1  registered destination write enable.
- mem_wdata_o  out  32  registered write data.
- mem_hi_o  out  32  registered HI data.
- mem_lo_o  out  32  registered LO data.
- mem_whilo_o  out  1  registered HI/LO write enable.
- hilo_temp_o  out  64  accumulator fed back to execute.
- cnt_o  out  2  pass counter fed back to execute.
- perf_bubble_o  out  32  bubbles inserted (see Configuration).
- perf_hilo_o  out  32  HI/LO writes forwarded (see Configuration).

## Operation
- **Bubble** means: all mem_* outputs = 0, so no register write and no HI/LO write.
- **Register $0 suppression:** the captured mem_wreg_o is ex_wreg_i AND (ex_wd_i != 0). A write to $0 is never forwarded.
- **Per-edge update,** evaluated in priority order:
  1. flush_i=1: bubble; hilo_temp_o=0; cnt_o=0.
  2. stall_ex_i=1, stall_mem_i=0: bubble; hilo_temp_o <= ex_hilo_temp_i; cnt_o <= ex_cnt_i.
  3. stall_ex_i=1, stall_mem_i=1: mem_* outputs hold; hilo_temp_o <= ex_hilo_temp_i; cnt_o <= ex_cnt_i.
  4. stall_ex_i=0, stall_mem_i=0: capture all ex_* into mem_*; hilo_temp_o=0; cnt_o=0.
  5. stall_ex_i=0, stall_mem_i=1: illegal, because the controller stalls monotonically. All outputs hold.
- **Flush with stall:** flush overrides stall. Accumulator state is dropped.
- **Accumulator capture:** hilo_temp_o/cnt_o are captured raw. There is no arithmetic and no saturation; cnt value 3 passes through unchanged.

## Timing
- **Reset:** while rst=1, every output is 0, including both perf counters. This takes effect immediately, independent of clk.
- **Reset release:** the first rising edge after rst falls applies the normal rules.
- **Latency:** one cycle. A value on ex_* at edge N is visible on mem_* after edge N.
- **Accumulator round trip:** ex_hilo_temp_i/ex_cnt_i at edge N reach execute as hilo_temp_o/cnt_o after edge N, ready for the next pass in cycle N+1.
- **Combinational paths:** none from inputs to outputs.

## Configuration
- Macro: `EX_MEM_PERF_EN`.
- **Defined:**
  - perf_bubble_o increments by 1 on each edge taking rule 1 or rule 2.
  - perf_hilo_o increments on each rule-4 edge with ex_whilo_i=1.
  - Both counters are 32-bit and wrap from 0xFFFFFFFF to 0.
  - Both counters are cleared only by rst.
- **Undefined:** both outputs are tied to 0 and no counter flops exist.

## Test plan
- **Reset mid-run:** capture ex_wdata_i=0x12345678, wd=5, wreg=1, then assert rst between edges -> every output reads 0 immediately, before the next edge.
- **Normal capture:** no stall, ex_wd_i=3, wreg=1, wdata=0xDEADBEEF, whilo=1, hi=0x1, lo=0x2 -> next cycle mem_* carry exactly those values; hilo_temp_o=0.
- **$0 suppression:** ex_wd_i=0, ex_wreg_i=1 -> mem_wreg_o=0; mem_wdata_o still equals ex_wdata_i.
- **Accumulate stall:** stall_ex_i=1, stall_mem_i=0, ex_hilo_temp_i=0x00000001_FFFFFFFE, ex_cnt_i=1 -> bubble on mem_*; hilo_temp_o=0x00000001_FFFFFFFE; cnt_o=1. Then release the stall with ex_cnt_i=2 -> capture, and hilo_temp_o/cnt_o return to 0.
- **Flush over stall:** flush_i=1 together with stall_ex_i=1 and stall_mem_i=1 -> bubble, hilo_temp_o=0, cnt_o=0. With `EX_MEM_PERF_EN`, perf_bubble_o increments by 1.
- **Counter wrap (`EX_MEM_PERF_EN`):** force perf_hilo_o to 0xFFFFFFFF, then capture one ex_whilo_i=1 instruction -> perf_hilo_o=0.
